// File: rtl/riscv_mux_arbiter.sv
// rtl/riscv_mux_arbiter.sv - round-robin arbiter feeding a registered single-entry output stage
// Optional burst lock per requester is enabled by defining RISCV_ARB_LOCK_EN.
module riscv_mux_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*XLEN-1:0]    i_req_concat_data,
`ifdef RISCV_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         i_req_lock,
`endif
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_out_valid,
    output logic [XLEN-1:0]          o_out_data,
    output logic [$clog2(N_REQ)-1:0] o_out_sel,
    input  logic                     i_out_ready
);

    localparam int SEL_W = $clog2(N_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] gnt_idx;
    logic             found;
    logic             load;
    logic             transfer;

    // Search from ptr upward, wrapping, and take the first valid requester.
    always_comb begin : grant_search
        int cand;
        cand    = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr) + i) % N_REQ;
            if (!found && i_req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = SEL_W'(cand);
            end
        end
    end

    assign o_out_valid = (state == FULL);
    assign load        = !o_out_valid || i_out_ready;
    assign transfer    = i_rstn && load && found;

    always_comb begin
        o_req_ready = '0;
        if (transfer) begin
            o_req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        if (gnt_idx == SEL_W'(N_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = gnt_idx + SEL_W'(1);
        end
`ifdef RISCV_ARB_LOCK_EN
        // A locked grant keeps the winner at top priority for its next word.
        if (i_req_lock[gnt_idx]) begin
            ptr_next = gnt_idx;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!transfer && i_out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= EMPTY;
            ptr        <= '0;
            o_out_data <= '0;
            o_out_sel  <= '0;
        end else begin
            state <= state_next;
            if (transfer) begin
                o_out_data <= i_req_concat_data[gnt_idx*XLEN +: XLEN];
                o_out_sel  <= gnt_idx;
                ptr        <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mux_arbiter.sv
// tb/tb_riscv_mux_arbiter.sv - directed and randomized bench for riscv_mux_arbiter
module tb_riscv_mux_arbiter;

`ifdef RISCV_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [95:0] req_data = '0;
    logic        out_ready = 1'b0;
    logic [2:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
`ifdef RISCV_ARB_LOCK_EN
    logic [2:0]  req_lock = '0;
`endif

    int checks = 0;
    int failures = 0;

    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_sel = 0;
    logic [2:0]  last_ready;

    riscv_mux_arbiter #(.N_REQ(3), .XLEN(32)) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_req_valid       (req_valid),
        .i_req_concat_data (req_data),
`ifdef RISCV_ARB_LOCK_EN
        .i_req_lock        (req_lock),
`endif
        .o_req_ready       (req_ready),
        .o_out_valid       (out_valid),
        .o_out_data        (out_data),
        .o_out_sel         (out_sel),
        .i_out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check grant before the edge, advance the model, check the output stage.
    task automatic cycle(input logic [2:0] v, input logic [95:0] d, input logic ordy,
                         input logic rn, input logic [2:0] lk);
        int g;
        int c;
        logic [2:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        rstn      = rn;
`ifdef RISCV_ARB_LOCK_EN
        req_lock  = lk;
`endif
        g = -1;
        exp_rdy = '0;
        if (rn && (!m_valid || ordy)) begin
            for (int k = 0; k < 3; k++) begin
                c = (m_ptr + k) % 3;
                if (g < 0 && v[c]) g = c;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        #3;
        last_ready = req_ready;
        chk("ready", {29'b0, req_ready}, {29'b0, exp_rdy});
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g*32 +: 32];
            m_sel   = g;
            m_ptr   = (LOCK_EN && lk[g]) ? g : (g + 1) % 3;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_data", out_data, m_data);
        chk("out_sel", {30'b0, out_sel}, 32'(m_sel));
    endtask

    logic [95:0] rot_d;
    logic [31:0] rot_exp [4];
    int          rot_sel [4];

    initial begin
        rot_d = {32'h33333333, 32'h22222222, 32'h11111111};
        rot_exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h11111111};
        rot_sel = '{0, 1, 2, 0};
        @(posedge clk);
        #1;

        // reset with everyone requesting
        cycle(3'b111, rot_d, 1'b1, 1'b0, 3'b000);
        cycle(3'b111, rot_d, 1'b1, 1'b0, 3'b000);
        chk("rst_ready", {29'b0, last_ready}, 32'h0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_sel", {30'b0, out_sel}, 32'h0);

        // rotation at full throughput
        for (int i = 0; i < 4; i++) begin
            cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
            chk("rot_sel", {30'b0, out_sel}, 32'(rot_sel[i]));
            chk("rot_data", out_data, rot_exp[i]);
        end

        // stall holding sel=1, then release to requester 2
        cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
        chk("stall_pre_sel", {30'b0, out_sel}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(3'b111, rot_d, 1'b0, 1'b1, 3'b000);
            chk("stall_ready", {29'b0, last_ready}, 32'h0);
            chk("stall_sel", {30'b0, out_sel}, 32'd1);
            chk("stall_data", out_data, 32'h22222222);
        end
        cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
        chk("release_sel", {30'b0, out_sel}, 32'd2);

        // wrap search from ptr=2 to sole requester 0
        cycle(3'b010, rot_d, 1'b1, 1'b1, 3'b000);
        cycle(3'b001, {64'h0, 32'hDEADBEEF}, 1'b1, 1'b1, 3'b000);
        chk("wrap_ready", {29'b0, last_ready}, 32'h1);
        chk("wrap_data", out_data, 32'hDEADBEEF);
        chk("wrap_sel", {30'b0, out_sel}, 32'd0);

        // drain to empty
        cycle(3'b000, rot_d, 1'b1, 1'b1, 3'b000);
        chk("drain_valid", {31'b0, out_valid}, 32'h0);

        // reset during a stall discards the held word
        cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
        cycle(3'b111, rot_d, 1'b0, 1'b1, 3'b000);
        cycle(3'b111, rot_d, 1'b1, 1'b0, 3'b000);
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst_ready", {29'b0, last_ready}, 32'h0);

        if (LOCK_EN) begin
            cycle(3'b001, rot_d, 1'b1, 1'b1, 3'b000);
            for (int i = 0; i < 3; i++) begin
                cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b010);
                chk("lock_sel", {30'b0, out_sel}, 32'd1);
            end
            cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
            chk("unlock_sel", {30'b0, out_sel}, 32'd1);
            cycle(3'b111, rot_d, 1'b1, 1'b1, 3'b000);
            chk("after_unlock_sel", {30'b0, out_sel}, 32'd2);
        end

        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0),
                  3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
